can_rx_fetch: RTL and testbench

CAN_RX_FETCH -- requirements
Module: can_rx_fetch

---
 rtl/can_rx_fetch.sv | 164 ++++++++++++++++
 tb/tb_can_rx_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_fetch.sv
// SJA1000 receive-buffer fetcher: on an interrupt, reads IR, pulls a 13-byte frame
// from registers 16..28 into a byte FIFO, then releases the receive buffer.
module can_rx_fetch #(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        can_int_n,
    output logic [31:0] acc_addr_o,
    output logic        acc_wren_o,
    output logic        acc_rden_o,
    output logic [31:0] acc_din_o,
    input  logic [31:0] acc_dout_i,
    input  logic        acc_valid_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_last_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [7:0]  overrun_cnt_o,
    output logic        timeout_err_o
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned FRAME_LEN = 13;
    localparam logic [PW-1:0] MAX_FILL  = PW'(FIFO_DEPTH - FRAME_LEN);
    localparam logic [4:0]    BUF_FIRST = 5'd16;
    localparam logic [4:0]    BUF_LAST  = 5'd28;
    localparam logic [7:0]    ADDR_IR   = 8'd3;
    localparam logic [7:0]    ADDR_CMR  = 8'd1;
    localparam logic [7:0]    CMD_RRB   = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        RD_IR,
        WT_IR,
        RD_BUF,
        WT_BUF,
        WR_CMR,
        WT_CMR
    } state_t;

    state_t          state, state_nxt;
    logic            sync1, sync2;
    logic            irq;
    logic [4:0]      bptr;
    logic [PW-1:0]   wr_spec, wr_cmt, rd_ptr;
    logic [PW-1:0]   fill;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [8:0]      head;
    logic [TW-1:0]   tmo_cnt;
    logic            in_wait, expired, has_room, pop, buf_wr, last_byte;
    logic [7:0]      addr8, din8;
    logic            unused_dout;

    assign unused_dout = ^acc_dout_i[31:8];

    assign irq       = ~sync2;
    assign fill      = wr_cmt - rd_ptr;
    assign has_room  = (fill <= MAX_FILL);
    assign rx_valid_o = (fill != '0);
    assign pop       = rx_valid_o & rx_ready_i;
    assign in_wait   = (state == WT_IR) || (state == WT_BUF) || (state == WT_CMR);
    assign expired   = in_wait && !acc_valid_i && (tmo_cnt == TW'(TIMEOUT));
    assign buf_wr    = (state == WT_BUF) && acc_valid_i;
    assign last_byte = (bptr == BUF_LAST);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign rx_byte_o = rx_valid_o ? head[7:0] : '0;
    assign rx_last_o = rx_valid_o ? head[8] : 1'b0;

    assign acc_addr_o = {24'h0, addr8};
    assign acc_din_o  = {24'h0, din8};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        acc_rden_o = 1'b0;
        acc_wren_o = 1'b0;
        addr8      = '0;
        din8       = '0;
        case (state)
            IDLE:   if (en_i && irq && has_room) state_nxt = RD_IR;
            RD_IR: begin
                acc_rden_o = 1'b1;
                addr8      = ADDR_IR;
                state_nxt  = WT_IR;
            end
            WT_IR: begin
                if (acc_valid_i) state_nxt = acc_dout_i[0] ? RD_BUF : IDLE;
                else if (expired) state_nxt = IDLE;
            end
            RD_BUF: begin
                acc_rden_o = 1'b1;
                addr8      = {3'b000, bptr};
                state_nxt  = WT_BUF;
            end
            WT_BUF: begin
                if (acc_valid_i) state_nxt = last_byte ? WR_CMR : RD_BUF;
                else if (expired) state_nxt = IDLE;
            end
            WR_CMR: begin
                acc_wren_o = 1'b1;
                addr8      = ADDR_CMR;
                din8       = CMD_RRB;
                state_nxt  = WT_CMR;
            end
            WT_CMR: if (acc_valid_i || expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && buf_wr) mem[wr_spec[AW-1:0]] <= {last_byte, acc_dout_i[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            bptr          <= '0;
            wr_spec       <= '0;
            wr_cmt        <= '0;
            rd_ptr        <= '0;
            tmo_cnt       <= '0;
            overrun_cnt_o <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            sync1 <= can_int_n;
            sync2 <= sync1;

            if (in_wait && !acc_valid_i && !expired) tmo_cnt <= tmo_cnt + 1'b1;
            else                                     tmo_cnt <= '0;

            if ((state == WT_IR) && acc_valid_i) begin
                if (acc_dout_i[3] && (overrun_cnt_o != 8'hFF))
                    overrun_cnt_o <= overrun_cnt_o + 8'd1;
                bptr <= BUF_FIRST;
            end

            // The committed pointer jumps straight to the post-write speculative
            // value, so a whole frame becomes visible in the cycle its last byte lands.
            if (buf_wr) begin
                wr_spec <= wr_spec + 1'b1;
                if (last_byte) wr_cmt <= wr_spec + 1'b1;
                else           bptr   <= bptr + 5'd1;
            end

            if (expired) begin
                timeout_err_o <= 1'b1;
                wr_spec       <= wr_cmt;
            end

            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_can_rx_fetch.sv
// Scoreboard bench for can_rx_fetch with a behavioural SJA1000 register/engine model.
module tb_can_rx_fetch;

    logic        clk = 1'b0;
    logic        rst, en_i, can_int_n;
    logic [31:0] acc_addr_o, acc_din_o, acc_dout_i;
    logic        acc_wren_o, acc_rden_o, acc_valid_i;
    logic [7:0]  rx_byte_o, overrun_cnt_o;
    logic        rx_last_o, rx_valid_o, rx_ready_i, timeout_err_o;

    always #5 clk = ~clk;

    can_rx_fetch #(.TIMEOUT(255), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .can_int_n(can_int_n),
        .acc_addr_o(acc_addr_o), .acc_wren_o(acc_wren_o), .acc_rden_o(acc_rden_o),
        .acc_din_o(acc_din_o), .acc_dout_i(acc_dout_i), .acc_valid_i(acc_valid_i),
        .rx_byte_o(rx_byte_o), .rx_last_o(rx_last_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .overrun_cnt_o(overrun_cnt_o), .timeout_err_o(timeout_err_o)
    );

    int checks = 0, passes = 0;
    int frames_posted = 0, frames_released = 0, doi_posted = 0, doi_taken = 0;
    int next_frame = 0;
    int rd_seen = 0, wr_seen = 0, buf_reads = 0;
    int ready_mode = 0, cyc = 0, wait_cnt = 0;
    logic acc_chk_en = 1'b1, byte_chk_en = 1'b1, drop_en = 1'b0, drop = 1'b0;
    logic [7:0] resp = '0, cap_addr = '0;
    logic [16:0] exp_acc[$];
    logic [8:0]  exp_bytes[$];

    // Interrupt is pending while an unreleased frame or an unread overrun exists.
    assign can_int_n = !((frames_posted > frames_released) || (doi_posted != doi_taken));

    function automatic logic [7:0] frame_byte(input int k, input int i);
        return 8'(32'h10 + k * 32 + i);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [84:0] outs();
        return {acc_addr_o, acc_din_o, acc_wren_o, acc_rden_o, rx_byte_o,
                rx_last_o, rx_valid_o, overrun_cnt_o, timeout_err_o};
    endfunction

    task automatic push_frame_exp();
        exp_acc.push_back({1'b0, 8'd3, 8'd0});
        for (int i = 0; i < 13; i++) begin
            exp_acc.push_back({1'b0, 8'(16 + i), 8'd0});
            exp_bytes.push_back({(i == 12), frame_byte(next_frame, i)});
        end
        exp_acc.push_back({1'b1, 8'd1, 8'h04});
        next_frame++;
    endtask

    task automatic post_frame();
        push_frame_exp();
        frames_posted++;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_acc.size() == 0 && exp_bytes.size() == 0) break;
        end
        chk("drain_pending", exp_acc.size() + exp_bytes.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    // Register-access engine: answers each request two cycles later.
    initial begin
        acc_valid_i = 1'b0;
        acc_dout_i  = '0;
        forever begin
            @(negedge clk);
            acc_valid_i = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0 && !drop) begin
                    acc_valid_i = 1'b1;
                    acc_dout_i  = {24'h0, resp};
                end
            end else if (acc_rden_o || acc_wren_o) begin
                cap_addr = acc_addr_o[7:0];
                drop     = drop_en && acc_rden_o && (cap_addr == 8'd20);
                resp     = '0;
                if (acc_wren_o) begin
                    if (cap_addr == 8'd1 && acc_din_o[7:0] == 8'h04) frames_released++;
                end else if (cap_addr == 8'd3) begin
                    resp = {4'b0, (doi_posted != doi_taken), 2'b0, (frames_posted > frames_released)};
                    doi_taken = doi_posted;
                end else begin
                    resp = frame_byte(frames_released, int'(cap_addr) - 16);
                end
                wait_cnt = 2;
            end
        end
    end

    initial begin
        rx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rx_ready_i = (ready_mode == 1) || ((ready_mode == 2) && (cyc % 5 == 0));
        end
    end

    // Access monitor.
    initial forever begin
        @(negedge clk);
        if (acc_rden_o || acc_wren_o) begin
            if (acc_rden_o) rd_seen++;
            if (acc_wren_o) wr_seen++;
            if (acc_rden_o && acc_addr_o[7:0] >= 8'd16) buf_reads++;
            if (acc_chk_en) begin
                if (exp_acc.size() == 0) begin
                    checks++;
                    $display("FAIL acc_unexpected: got addr %0h wr %0b expected no access",
                             acc_addr_o, acc_wren_o);
                end else begin
                    logic [16:0] e;
                    e = exp_acc.pop_front();
                    chk("access", {acc_wren_o, acc_rden_o, acc_addr_o, acc_din_o},
                        {e[16], ~e[16], 24'h0, e[15:8], 24'h0, e[7:0]});
                end
            end
        end
    end

    // Byte monitor.
    initial forever begin
        @(negedge clk);
        if (rx_valid_o && rx_ready_i && byte_chk_en) begin
            if (exp_bytes.size() == 0) begin
                checks++;
                $display("FAIL rx_unexpected: got %0h last %0b expected no byte", rx_byte_o, rx_last_o);
            end else begin
                chk("rx_byte", {rx_last_o, rx_byte_o}, exp_bytes.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n, k, w0, r0, b0;
        rst  = 1'b1;
        en_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), '0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_no_access", rd_seen + wr_seen, 0);

        // Single frame, consumer always ready.
        ready_mode = 1;
        post_frame();
        wait_drain(400);
        chk("rx_empty_after_frame", rx_valid_o, 0);

        // Overrun only, no receive indication.
        w0 = wr_seen; b0 = buf_reads;
        exp_acc.push_back({1'b0, 8'd3, 8'd0});
        doi_posted++;
        wait_drain(200);
        chk("overrun_cnt", overrun_cnt_o, 1);
        chk("doi_no_cmr", wr_seen - w0, 0);
        chk("doi_no_buf_reads", buf_reads - b0, 0);

        // Backpressure: second frame must wait for room.
        ready_mode = 0; r0 = rd_seen;
        post_frame();
        post_frame();
        repeat (150) @(negedge clk);
        chk("bp_hold_reads", rd_seen - r0, 14);
        chk("bp_rx_valid", rx_valid_o, 1);
        ready_mode = 1;
        wait_drain(600);

        // Slow consumer across several frames: pointers wrap, pops overlap commits.
        ready_mode = 2;
        repeat (4) post_frame();
        wait_drain(2000);

        // Engine drops the read of address 20.
        ready_mode = 0; acc_chk_en = 1'b0; byte_chk_en = 1'b0;
        w0 = wr_seen; drop_en = 1'b1;
        frames_posted++;
        k = 0;
        while (!(acc_rden_o && acc_addr_o[7:0] == 8'd20) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drop_read_seen", (k < 300), 1);
        n = 0;
        while (!timeout_err_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", (n >= 250 && n <= 262), 1);
        chk("timeout_err", timeout_err_o, 1);
        chk("timeout_rx_valid", rx_valid_o, 0);
        chk("timeout_no_cmr", wr_seen - w0, 0);
        drop_en = 1'b0;
        frames_posted = frames_released;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        frames_posted = frames_released;
        next_frame    = frames_released;
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a frame, then full refetch.
        b0 = buf_reads;
        frames_posted++;
        k = 0;
        while ((buf_reads - b0) < 5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_frame_reads", (buf_reads - b0) >= 5, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", outs(), '0);
        repeat (3) @(negedge clk);
        push_frame_exp();
        acc_chk_en = 1'b1; byte_chk_en = 1'b1; ready_mode = 1;
        rst = 1'b0;
        wait_drain(400);
        chk("final_rx_empty", rx_valid_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
